serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around one instance of the team's fullAdder cell.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Steps the single full adder through one bit per cycle, LSB first, with a registered carry.
- Returns the result over a second valid/ready handshake.
- Trades latency for area wherever one adder cell must serve a multi-bit datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
sub  input  1  0: A+B, 1: A-B (sampled with operands)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
cout  output  1  final carry out (for sub: 1 = no borrow)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, and all internal shift registers, carry and counter = 0.
- FSM states: IDLE, RUN, DONE (2-bit encoded).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shA=a; load shB = sub ? ~b : b; carry=sub; cnt=0; clear the sum shift register; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the fullAdder is fed x=shA[0], y=shB[0], cin=carry.
  - Its s output shifts into the sum register MSB; the sum register shifts right.
  - shA and shB shift right with zero fill.
  - carry <= cout of the cell; cnt <= cnt+1.
  - When cnt==WIDTH-1 (last bit processed this cycle): go to DONE.
- DONE:
  - out_valid=1; sum holds the full result; cout = final carry.
  - Outputs stay stable until out_ready is high.
  - On out_valid&&out_ready: go to IDLE, out_valid drops next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid rises after exactly WIDTH further edges.
  - Minimum accept-to-accept spacing is WIDTH+2 cycles with out_ready held high.
- Width rule: result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- Simultaneous events:
  - in_valid while not IDLE: ignored; operands are not captured, in_ready=0.
  - out_ready asserted before DONE: no effect.
- Stability: a, b and sub are sampled only on the accept edge; later changes do not affect an operation in flight.
- Reset mid-operation: aborts immediately and asynchronously; all state returns to reset values; no partial result is ever presented.
- Cell instantiation: exactly one fullAdder instance; no other adder logic is permitted.

Optional Feature:
SERIAL_ADDER_OVERFLOW_EN
- Defined:
  - Adds output port overflow (1 bit, reset 0), valid with out_valid.
  - Signed overflow = carry into MSB XOR carry out of MSB, captured during the last RUN cycle.
- Undefined: port and logic are absent; the block is otherwise identical.

Test Plan:
- Reset, no stimulus -> in_ready=1, out_valid=0, sum=0x00, cout=0 (WIDTH=8).
- a=0x35, b=0x1A, sub=0, out_ready=1 -> out_valid exactly 8 cycles after accept, sum=0x4F, cout=0, one-cycle DONE then IDLE.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVERFLOW_EN, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, overflow=1.
- a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow). Then a=0x20, b=0x10, sub=1 -> sum=0x10, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid toggles with new operands -> sum/cout stable, in_ready=0, no capture; result unchanged when out_ready rises.
- rst_n pulsed low at RUN cycle 3 of a=0xAA, b=0x55 -> immediate IDLE with reset values; next op a=0x01, b=0x02 -> sum=0x03.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add/subtract sequencer. A single fullAdder cell is stepped one
// bit per cycle, LSB first, with a registered carry between steps. Operands
// arrive over a valid/ready handshake and the result leaves over a second
// valid/ready handshake. This trades WIDTH cycles of latency for a datapath
// that contains only one adder cell.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//   CNT_W  bit-counter width, derived from WIDTH (not meant to be overridden)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   controller can accept operands (high only in IDLE)
//   a, b       operands (unsigned or two's complement)
//   sub        0: a+b, 1: a-b (sampled together with the operands)
//   out_valid  result valid (high only in DONE)
//   out_ready  downstream accepts result
//   sum        result bits, modulo 2^WIDTH
//   cout       final carry out (for subtraction: 1 = no borrow)
//   overflow   signed overflow, valid with out_valid
//              (present only when SERIAL_ADDER_OVERFLOW_EN is defined)
//
// Build option:
//   SERIAL_ADDER_OVERFLOW_EN  adds the overflow output and its capture logic.
//
// State table:
//   IDLE | waiting for an operand pair, in_ready=1
//   RUN  | stepping the adder cell, one bit per cycle
//   DONE | result presented, held until out_ready
// -----------------------------------------------------------------------------

// One-bit full adder cell; the controller below uses exactly one of these.
module fullAdder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic load;
  logic step;
  logic last;

  logic fa_s;
  logic fa_cout;

  fullAdder u_fa (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serial datapath. Subtraction is a + ~b + 1, so the inverted B operand is
  // loaded and the carry is seeded with the sub bit. Each step retires the
  // LSB of both operands and pushes one result bit into the sum MSB; after
  // WIDTH steps the first result bit has reached bit 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      sh_a  <= a;
      sh_b  <= sub ? ~b : b;
      sum_q <= '0;
      carry <= sub;
      cnt   <= '0;
    end else if (step) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      sum_q <= {fa_s, sum_q[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // On the last step the registered carry is the carry into the MSB and the
  // cell's cout is the carry out of it; their XOR is signed overflow.
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (load) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= carry ^ fa_cout;
    end
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,.overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cycle;
  } exp_t;

  exp_t sb[$];

  bit rand_bp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub);
    exp_t e;
    int ia, ib, sa, sb_s, sr;
    ia = int'(ma);
    ib = int'(mb);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb_s = (ib >= 128) ? ib - 256 : ib;
    if (msub) begin
      e.sum  = W'((ia - ib + 256) % 256);
      e.cout = (ia >= ib);
      sr     = sa - sb_s;
    end else begin
      e.sum  = W'((ia + ib) % 256);
      e.cout = ((ia + ib) >= 256);
      sr     = sa + sb_s;
    end
    e.ovf = (sr > 127) || (sr < -128);
    e.acc_cycle = 0;
    return e;
  endfunction

  // Caller is at posedge+#2. Returns at posedge+#2 of the accept edge.
  task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input bit push, output int acc);
    bit rdy;
    bit got;
    exp_t e;
    got = 0;
    acc = -1;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    sub = isub;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        got = 1;
        acc = cycle;
        break;
      end
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = $urandom_range(0, 1);
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e = model(ia, ib, isub);
      e.acc_cycle = acc;
      sb.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Random backpressure driver.
  always @(posedge clk) begin
    #2;
    if (rand_bp) out_ready = $urandom_range(0, 1);
  end

  // Monitor / scoreboard.
  logic         prev_valid = 0;
  logic         prev_ready = 0;
  logic         prev_hs = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_ready = 0;
      prev_hs    = 0;
    end else begin
      if (prev_hs) begin
        check("done_to_idle_valid", out_valid, 1'b0);
        check("done_to_idle_ready", in_ready, 1'b1);
      end
      if (out_valid) begin
        check("in_ready_in_done", in_ready, 1'b0);
        if (!prev_valid) begin
          if (sb.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
          else check("latency", cycle - sb[0].acc_cycle, W);
        end else if (!prev_ready) begin
          check("hold_sum", sum, prev_sum);
          check("hold_cout", cout, prev_cout);
        end
        if (out_ready && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
`ifdef SERIAL_ADDER_OVERFLOW_EN
          check("overflow", overflow, e.ovf);
`endif
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_hs    = out_valid && out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
    end
  end

  initial begin : main
    int acc0, acc1, acc2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst_overflow", overflow, 1'b0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed cases.
    issue_op(8'h35, 8'h1A, 1'b0, 1, acc0);
    idle_cycles(12);
    issue_op(8'hFF, 8'h01, 1'b0, 1, acc0);
    idle_cycles(12);
    issue_op(8'h7F, 8'h01, 1'b0, 1, acc0);
    idle_cycles(12);
    issue_op(8'h10, 8'h20, 1'b1, 1, acc0);
    idle_cycles(12);
    issue_op(8'h20, 8'h10, 1'b1, 1, acc0);
    idle_cycles(12);

    // Back-to-back spacing with out_ready high.
    issue_op(8'h01, 8'h01, 1'b0, 1, acc1);
    issue_op(8'h80, 8'h80, 1'b0, 1, acc2);
    check("accept_spacing", acc2 - acc1, W + 2);
    idle_cycles(12);

    // Backpressure while new operands are offered.
    out_ready = 1'b0;
    issue_op(8'h5C, 8'h33, 1'b0, 1, acc0);
    begin
      bit seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1; break; end
      end
      check("bp_reach_done", seen, 1'b1);
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom;
      b = $urandom;
      sub = $urandom_range(0, 1);
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle_cycles(12);
    @(negedge clk);
    check("bp_no_capture", out_valid, 1'b0);
    check("bp_sb_empty", sb.size(), 0);
    @(posedge clk);
    #2;

    // Reset during RUN.
    issue_op(8'hAA, 8'h55, 1'b0, 0, acc0);
    idle_cycles(2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 8'h00);
    check("midrst_cout", cout, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(12);
    @(negedge clk);
    check("midrst_no_result", out_valid, 1'b0);
    @(posedge clk);
    #2;
    issue_op(8'h01, 8'h02, 1'b0, 1, acc0);
    idle_cycles(12);

    // Randomized phase with random backpressure.
    rand_bp = 1;
    for (int n = 0; n < 40; n++) begin
      issue_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1, acc0);
      idle_cycles($urandom_range(0, 3));
    end
    rand_bp = 0;
    out_ready = 1'b1;

    begin
      bit drained = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (sb.size() == 0 && !out_valid) begin drained = 1; break; end
      end
      check("drain", drained, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
